fifo_stream_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO: it drains a commanded number of words from the FIFO read port and presents them as a valid/ready stream to a downstream consumer. It drives the FIFO's read enable, absorbs the FIFO's one-cycle registered read latency, and holds data in a 2-entry skid buffer so downstream back-pressure never loses a word. It sits between `sync_fifo` and any stream sink (UART TX, DMA write port).

---
 rtl/fifo_rdr_pkg.sv | 30 +++
 rtl/fifo_rdr_skid.sv | 68 ++++++
 rtl/fifo_stream_reader.sv | 167 ++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rdr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rdr_pkg
// Shared types and constants for the FIFO stream reader.
//   rdr_state_e : controller FSM states (IDLE, RUN, DONE)
//   SKID_DEPTH  : entries in the output skid buffer
//   STALL_W     : width of the optional stall counter (FIFO_RDR_STATS_EN)
//   credit_ok() : read-issue credit test shared by the top level
// -----------------------------------------------------------------------------
package fifo_rdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rdr_state_e;

    localparam int SKID_DEPTH = 2;
    localparam int STALL_W    = 16;

    // A new read may issue only when every word already held or in flight,
    // less the word leaving this cycle, still leaves a free skid slot.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] w_used;
        w_used = {1'b0, occ} + {2'b00, inflight};
        return (w_used < (3'd2 + {2'b00, pop}));
    endfunction

endpackage

// File: rtl/fifo_rdr_skid.sv
// -----------------------------------------------------------------------------
// fifo_rdr_skid
// Two-entry skid buffer between the FIFO read data and the output stream.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push          : write i_push_data this cycle (registered read strobe)
//   i_push_data     : FIFO registered read data
//   i_pop_ready     : downstream ready; a pop happens on o_valid && i_pop_ready
//   o_valid, o_data : head of the buffer presented to the stream
//   o_occ           : current occupancy (0..2)
// -----------------------------------------------------------------------------
module fifo_rdr_skid
    import fifo_rdr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_mem [SKID_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic              w_pop;

    assign o_valid = (r_occ != 2'd0);
    assign w_pop   = o_valid && i_pop_ready;
    // Head entry drives the stream directly; it only moves on a pop, so the
    // presented word is stable while back-pressured.
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The credit rule upstream guarantees a push never lands on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !w_pop && (r_occ == 2'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Drains a commanded number of words from a synchronous FIFO (one-cycle
// registered read latency) and presents them as a valid/ready stream.
// Optional feature macro: FIFO_RDR_STATS_EN adds the stall_cnt output.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   cmd_valid/cmd_len      : burst request and length (0 = empty burst)
//   cmd_ready              : high only in IDLE
//   done                   : one-cycle pulse when the burst completes
//   fifo_empty             : FIFO empty flag
//   fifo_rd_en             : FIFO read strobe
//   fifo_rd_data           : FIFO read data, valid the cycle after fifo_rd_en
//   m_valid/m_data/m_ready : output stream
//   stall_cnt              : saturating stall counter (FIFO_RDR_STATS_EN only)
//   dbg_state              : current FSM state (rdr_state_e encoding)
//
// Handshakes: a transfer happens on every rising edge where valid && ready.
// A source never waits for ready before raising valid, and once valid is high
// it and its data stay unchanged until the transfer. This holds for both the
// command port (cmd_valid/cmd_ready) and the stream port (m_valid/m_ready).
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_rdr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               cmd_ready,
    output logic               done,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    output logic               m_valid,
    output logic [DATA_W-1:0]  m_data,
    input  logic               m_ready,
`ifdef FIFO_RDR_STATS_EN
    output logic [STALL_W-1:0] stall_cnt,
`endif
    output logic [1:0]         dbg_state
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    rdr_state_e       r_state;
    rdr_state_e       w_state_nxt;
    logic [LEN_W-1:0] r_issue_left;
    logic [LEN_W-1:0] r_accept_left;
    logic             r_inflight;
    logic [1:0]       w_occ;
    logic             w_pop;
    logic             w_accept;
    logic             w_credit_ok;

    assign w_pop       = m_valid && m_ready;
    assign w_credit_ok = credit_ok(w_occ, r_inflight, w_pop);
    assign fifo_rd_en  = (r_state == ST_RUN) && !fifo_empty &&
                         (r_issue_left != '0) && w_credit_ok;
    assign dbg_state   = r_state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // Last outstanding word leaves this cycle.
                if (w_pop && (r_accept_left == LEN_ONE)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- counters / read pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_left  <= '0;
            r_accept_left <= '0;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_accept) begin
                r_issue_left  <= cmd_len;
                r_accept_left <= cmd_len;
            end else begin
                if (fifo_rd_en) begin
                    r_issue_left <= r_issue_left - LEN_ONE;
                end
                if (w_pop) begin
                    r_accept_left <= r_accept_left - LEN_ONE;
                end
            end
        end
    end

    a_no_pop_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && (r_accept_left == '0)));

    // Read data lands in the skid buffer the cycle after the strobe.
    fifo_rdr_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (fifo_rd_data),
        .i_pop_ready (m_ready),
        .o_valid     (m_valid),
        .o_data      (m_data),
        .o_occ       (w_occ)
    );

`ifdef FIFO_RDR_STATS_EN
    // ---------------- stall statistics ----------------
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_stall;

    // Counts cycles lost to downstream back-pressure or to an empty FIFO
    // while reads are still owed.
    assign w_stall = (r_state == ST_RUN) &&
                     ((m_valid && !m_ready) || (fifo_empty && (r_issue_left != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Bench for fifo_stream_reader. A queue-based FIFO model feeds the DUT; a
// negedge monitor scores every stream transfer against the words the FIFO
// handed out and checks the read-credit bound. Directed tests check exact
// cycle timing; randomized bursts check data against the words written.
// Define FIFO_RDR_STATS_EN to also exercise stall_cnt.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;
    import fifo_rdr_pkg::*;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid    = 1'b0;
    logic [LEN_W-1:0]  cmd_len      = '0;
    logic              cmd_ready;
    logic              done;
    logic              fifo_empty   = 1'b1;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data = '0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready      = 1'b1;
    logic [1:0]        dbg_state;
`ifdef FIFO_RDR_STATS_EN
    logic [STALL_W-1:0] stall_cnt;
`endif

    fifo_stream_reader #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_len      (cmd_len),
        .cmd_ready    (cmd_ready),
        .done         (done),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
`ifdef FIFO_RDR_STATS_EN
        .stall_cnt    (stall_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] wr_req_q[$];  // words the bench writes into the FIFO
    logic [DATA_W-1:0] fifo_q[$];    // FIFO contents
    logic [DATA_W-1:0] exp_q[$];     // words read from the FIFO, not yet delivered
    logic [DATA_W-1:0] got_q[$];     // words delivered in the current burst
    logic [DATA_W-1:0] ref_q[$];     // words the current burst must deliver
    logic [DATA_W-1:0] pend_q[$];    // words to be written while the burst runs

    int   mode = 0;                  // m_ready: 0 high, 1 toggle, 2 random, 3 low
    int   rd_total = 0;
    int   pop_total = 0;
    int   burst_rd = 0;
    bit   pop_now;
    bit   prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- FIFO model (registered read, write at edge) ----------------
    always @(posedge clk) begin
        if (fifo_rd_en && (fifo_q.size() > 0)) begin
            fifo_rd_data <= fifo_q[0];
            exp_q.push_back(fifo_q[0]);
            void'(fifo_q.pop_front());
        end
        while (wr_req_q.size() > 0) fifo_q.push_back(wr_req_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // ---------------- stream / credit monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_total  = 0;
            pop_total = 0;
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            pop_now = m_valid && m_ready;
            if (prev_hold) begin
                chk("stable_valid", 32'(m_valid), 32'd1);
                chk("stable_data", 32'(m_data), 32'(prev_data));
            end
            if (fifo_rd_en) begin
                chk("rd_while_empty", 32'(fifo_empty), 32'd0);
                chk("credit_rule", 32'((rd_total - pop_total - int'(pop_now)) < 2), 32'd1);
                rd_total++;
                burst_rd++;
            end
            if (pop_now) begin
                if (exp_q.size() == 0) chk("pop_without_read", 32'd1, 32'd0);
                else chk("stream_order", 32'(m_data), 32'(exp_q.pop_front()));
                got_q.push_back(m_data);
                pop_total++;
            end
            chk("occupancy_max", 32'((rd_total - pop_total) <= 2), 32'd1);
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        #1;
    endtask

    task automatic issue_cmd(input int len);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        burst_rd  = 0;
        got_q.delete();
        step();
        cmd_valid = 1'b0;
        cmd_len   = '0;
    endtask

    task automatic load_words(input int n, input int n_now);
        logic [DATA_W-1:0] w;
        ref_q.delete();
        pend_q.delete();
        for (int i = 0; i < n; i++) begin
            w = DATA_W'($urandom);
            ref_q.push_back(w);
            if (i < n_now) wr_req_q.push_back(w);
            else pend_q.push_back(w);
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (pend_q.size() > 0 && $urandom_range(0, 1) == 1)
                wr_req_q.push_back(pend_q.pop_front());
            if (done) seen = 1'b1;
            else step();
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic finish_burst(input int len);
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("read_count", 32'(burst_rd), 32'(len));
        chk("word_count", 32'(got_q.size()), 32'(len));
        for (int i = 0; i < len && i < got_q.size(); i++)
            chk("word_value", 32'(got_q[i]), 32'(ref_q[i]));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    logic [DATA_W-1:0] rw [6];

    initial begin
        // Reset values
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        rst_n = 1'b1;
        step();

        // Single burst: exact cycle timing relative to the accept edge
        ref_q.delete();
        for (int i = 0; i < 4; i++) begin
            ref_q.push_back(DATA_W'(8'h11 + i));
            wr_req_q.push_back(DATA_W'(8'h11 + i));
        end
        step();
        step();
        issue_cmd(4);
        for (int k = 1; k <= 8; k++) begin
            chk("single_rd_en", 32'(fifo_rd_en), 32'(k >= 1 && k <= 4));
            chk("single_m_valid", 32'(m_valid), 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("single_m_data", 32'(m_data), 32'(ref_q[k-3]));
            chk("single_done", 32'(done), 32'(k == 7));
            chk("single_cmd_ready", 32'(cmd_ready), 32'(k == 8));
            if (k < 8) step();
        end
        chk("single_reads", 32'(burst_rd), 32'd4);
        chk("single_words", 32'(got_q.size()), 32'd4);

        // Zero-length burst
        issue_cmd(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("zero_rd_en", 32'(fifo_rd_en), 32'd0);
        step();
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("zero_reads", 32'(burst_rd), 32'd0);

        // Back-pressure: m_ready toggling every cycle
        ref_q.delete();
        for (int i = 0; i < 8; i++) begin
            ref_q.push_back(DATA_W'(8'hA0 + i));
            wr_req_q.push_back(DATA_W'(8'hA0 + i));
        end
        step();
        mode = 1;
        step();
        issue_cmd(8);
        wait_done(200);
        finish_burst(8);
        mode = 0;

        // Starved FIFO: nothing to read for 10 cycles
        load_words(3, 0);
        step();
        issue_cmd(3);
        for (int k = 0; k < 10; k++) begin
            chk("starve_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("starve_state", 32'(dbg_state), 32'(ST_RUN));
            step();
        end
        wait_done(100);
        finish_burst(3);

        // Randomized bursts, random m_ready, words trickling in
        mode = 2;
        for (int b = 0; b < 8; b++) begin
            int len;
            len = $urandom_range(0, 10);
            load_words(len, len / 2);
            step();
            issue_cmd(len);
            wait_done(400);
            finish_burst(len);
        end

        // Reset mid-burst with a word held and a read in flight
        mode = 3;
        for (int i = 0; i < 6; i++) begin
            rw[i] = DATA_W'($urandom);
            wr_req_q.push_back(rw[i]);
        end
        step();
        step();
        issue_cmd(6);
        step();
        step();
        chk("pre_reset_m_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("async_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("async_state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        step();
        rst_n = 1'b1;
        mode = 0;
        step();
        // The two words popped before reset are lost; the FIFO resumes at rw[2].
        ref_q.delete();
        ref_q.push_back(rw[2]);
        ref_q.push_back(rw[3]);
        issue_cmd(2);
        wait_done(50);
        finish_burst(2);
        ref_q.delete();
        ref_q.push_back(rw[4]);
        ref_q.push_back(rw[5]);
        issue_cmd(2);
        wait_done(50);
        finish_burst(2);

`ifdef FIFO_RDR_STATS_EN
        // m_valid rises in the third burst cycle; five held cycles follow.
        mode = 3;
        load_words(4, 4);
        step();
        step();
        step();
        issue_cmd(4);
        for (int k = 1; k < 8; k++) step();
        chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
        mode = 0;
        wait_done(50);
        finish_burst(4);
        issue_cmd(0);
        chk("stall_cnt_clear", 32'(stall_cnt), 32'd0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
